// File: rtl/accelerator_vector_float_divider.sv
// Element-wise binary64 vector divider: DATA_OUT[i] = DATA_A[i] / DATA_B[i].
// Operand pairs stream in under per-operand enables, and quotients stream out
// one per element. The quotient is computed combinationally from the operand
// values being captured. It is registered on the same edge that enters ENDER,
// so it is presented one clock after the second operand is taken.
//
// state   | meaning
// --------+---------------------------------------------------------------
// STARTER | idle; waits for START, latches SIZE_IN
// INPUT   | collecting the current A/B pair (either order, last value wins)
// ENDER   | quotient presented; ignores operands; back to INPUT or STARTER
module accelerator_vector_float_divider #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic                    DATA_B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic                    DATA_ENABLE,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    OVERFLOW_OUT
);

  typedef enum logic [1:0] {STARTER, INPUT, ENDER} state_t;

  state_t                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_q, size_d;
  logic [CONTROL_SIZE-1:0] index_q, index_d;
  logic [DATA_SIZE-1:0]    a_q, a_d, b_q, b_d;
  logic                    a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic                    ready_q, ready_d;
  logic                    data_enable_q, data_enable_d;
  logic                    out_enable_q, out_enable_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic                    overflow_q, overflow_d;

  // binary64 divide, round-to-nearest-even, IEEE special values, subnormals honoured
  function automatic logic [63:0] fdiv64(input logic [63:0] a, input logic [63:0] b);
    logic               sign;
    logic [10:0]        ea, eb, base;
    logic [51:0]        fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [52:0]        ma, mb, m, mx;
    logic signed [13:0] xa, xb, ex, dsh;
    logic [55:0]        q;
    logic [53:0]        rem, mr;
    logic               g, s, gx, sx, inc;
    logic [6:0]         sh;
    logic [117:0]       dn;
    logic [62:0]        mag;
    logic [63:0]        res;
    sign   = a[63] ^ b[63];
    ea     = a[62:52];
    eb     = b[62:52];
    fa     = a[51:0];
    fb     = b[51:0];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea) & ~(|fa);
    b_zero = ~(|eb) & ~(|fb);

    // unpack and normalise so bit 52 of each mantissa is set
    ma = {|ea, fa};
    mb = {|eb, fb};
    xa = (|ea) ? $signed({3'b000, ea}) : 14'sd1;
    xb = (|eb) ? $signed({3'b000, eb}) : 14'sd1;
    for (int i = 0; i < 52; i++) begin
      if (!ma[52]) begin
        ma = ma << 1;
        xa = xa - 14'sd1;
      end
      if (!mb[52]) begin
        mb = mb << 1;
        xb = xb - 14'sd1;
      end
    end

    // restoring division: q[55] has weight 1, q[54:0] are the fraction bits
    q   = '0;
    rem = {1'b0, ma};
    for (int i = 55; i >= 0; i--) begin
      if (rem >= {1'b0, mb}) begin
        q[i] = 1'b1;
        rem  = rem - {1'b0, mb};
      end
      rem = rem << 1;
    end

    ex = xa - xb + 14'sd1023;
    if (q[55]) begin
      m = q[55:3];
      g = q[2];
      s = (|q[1:0]) | (|rem);
    end else begin
      m  = q[54:2];
      g  = q[1];
      s  = q[0] | (|rem);
      ex = ex - 14'sd1;
    end

    // denormalise into the subnormal range; shifted-out bits fold into sticky
    dsh = 14'sd1 - ex;
    if (ex >= 14'sd1)        sh = 7'd0;
    else if (dsh > 14'sd64)  sh = 7'd64;
    else                     sh = dsh[6:0];
    dn  = {m, g, 64'b0} >> sh;
    mx  = dn[117:65];
    gx  = dn[64];
    sx  = s | (|dn[63:0]);
    inc = gx & (sx | mx[0]);
    mr  = {1'b0, mx} + {53'b0, inc};

    // adding the hidden bit onto (exp-1) lets a rounding carry bump the exponent
    base = (ex >= 14'sd1) ? (ex[10:0] - 11'd1) : 11'd0;
    mag  = {base, 52'b0} + {9'b0, mr};

    if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero))
      res = 64'h7FF8_0000_0000_0000;
    else if (a_inf | b_zero)
      res = {sign, 11'h7FF, 52'b0};
    else if (a_zero | b_inf)
      res = {sign, 63'b0};
    else if (ex >= 14'sd2047)
      res = {sign, 11'h7FF, 52'b0};
    else
      res = {sign, mag};
    return res;
  endfunction

  // state, operand and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= STARTER;
      size_q        <= '0;
      index_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      a_pend_q      <= 1'b0;
      b_pend_q      <= 1'b0;
      ready_q       <= 1'b0;
      data_enable_q <= 1'b0;
      out_enable_q  <= 1'b0;
      data_out_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      index_q       <= index_d;
      a_q           <= a_d;
      b_q           <= b_d;
      a_pend_q      <= a_pend_d;
      b_pend_q      <= b_pend_d;
      ready_q       <= ready_d;
      data_enable_q <= data_enable_d;
      out_enable_q  <= out_enable_d;
      data_out_q    <= data_out_d;
      overflow_q    <= overflow_d;
    end
  end

  // next-state, operand capture and registered-output decode
  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    index_d       = index_q;
    a_d           = a_q;
    b_d           = b_q;
    a_pend_d      = a_pend_q;
    b_pend_d      = b_pend_q;
    ready_d       = 1'b0;
    data_enable_d = 1'b0;
    out_enable_d  = 1'b0;
    data_out_d    = data_out_q;
    overflow_d    = overflow_q;
    case (state_q)
      STARTER: begin
        if (START) begin
          size_d   = SIZE_IN;
          index_d  = '0;
          a_pend_d = 1'b0;
          b_pend_d = 1'b0;
          if (SIZE_IN == '0) begin
            ready_d = 1'b1;
          end else begin
            data_enable_d = 1'b1;
            state_d       = INPUT;
          end
        end
      end
      INPUT: begin
        if (DATA_A_IN_ENABLE) begin
          a_d      = DATA_A_IN;
          a_pend_d = 1'b1;
        end
        if (DATA_B_IN_ENABLE) begin
          b_d      = DATA_B_IN;
          b_pend_d = 1'b1;
        end
        if (a_pend_d && b_pend_d) begin
          data_out_d   = fdiv64(a_d, b_d);
          overflow_d   = ~(|b_d[62:0]);
          out_enable_d = 1'b1;
          a_pend_d     = 1'b0;
          b_pend_d     = 1'b0;
          index_d      = index_q + CONTROL_SIZE'(1);
          if (index_d == size_q) ready_d = 1'b1;
          else                   data_enable_d = 1'b1;
          state_d      = ENDER;
        end
      end
      ENDER: begin
        // ready_q is high during ENDER exactly when this was the last element
        state_d = ready_q ? STARTER : INPUT;
      end
      default: state_d = STARTER;
    endcase
  end

  assign READY           = ready_q;
  assign DATA_ENABLE     = data_enable_q;
  assign DATA_OUT_ENABLE = out_enable_q;
  assign DATA_OUT        = data_out_q;
  assign OVERFLOW_OUT    = overflow_q;

endmodule

// File: tb/tb_accelerator_vector_float_divider.sv
// Directed bench for the vector float divider. The stimulus pushes hand-computed
// expected responses into a scoreboard queue, and an independent monitor pops
// and compares them whenever the DUT presents DATA_OUT_ENABLE or READY.
`timescale 1ns/1ps
module tb_accelerator_vector_float_divider;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY;
  logic [63:0] SIZE_IN = '0;
  logic        DATA_A_IN_ENABLE = 1'b0;
  logic        DATA_B_IN_ENABLE = 1'b0;
  logic [63:0] DATA_A_IN = '0;
  logic [63:0] DATA_B_IN = '0;
  logic        DATA_ENABLE;
  logic        DATA_OUT_ENABLE;
  logic [63:0] DATA_OUT;
  logic        OVERFLOW_OUT;

  accelerator_vector_float_divider #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIZE_IN(SIZE_IN),
    .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE), .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE),
    .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN), .DATA_ENABLE(DATA_ENABLE),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT(DATA_OUT), .OVERFLOW_OUT(OVERFLOW_OUT)
  );

  always #5 CLK = ~CLK;

  localparam logic [63:0] P_0  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] N_0  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] P_1  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] N_1  = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] P_2  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] P_3  = 64'h4008_0000_0000_0000;
  localparam logic [63:0] N_3  = 64'hC008_0000_0000_0000;
  localparam logic [63:0] P_4  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] P_5  = 64'h4014_0000_0000_0000;
  localparam logic [63:0] P_6  = 64'h4018_0000_0000_0000;
  localparam logic [63:0] P_8  = 64'h4020_0000_0000_0000;
  localparam logic [63:0] P_9  = 64'h4022_0000_0000_0000;
  localparam logic [63:0] N_9  = 64'hC022_0000_0000_0000;
  localparam logic [63:0] P_Q  = 64'h3FD0_0000_0000_0000;
  localparam logic [63:0] P_T  = 64'h3FD5_5555_5555_5555;
  localparam logic [63:0] P_H  = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] P_25 = 64'h4004_0000_0000_0000;
  localparam logic [63:0] P_MX = 64'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000;

  typedef struct packed {
    logic        has_data;
    logic [63:0] data;
    logic        ovf;
    logic        rdy;
    logic        nan;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors   = 0;
  int   checks   = 0;
  int   de_count = 0;

  function automatic exp_t mk(input logic has, input logic [63:0] d, input logic ovf,
                              input logic rdy, input logic nan);
    exp_t r;
    r.has_data = has;
    r.data     = d;
    r.ovf      = ovf;
    r.rdy      = rdy;
    r.nan      = nan;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: count DATA_ENABLE pulses, score every output event
  always @(negedge CLK) begin
    if (DATA_ENABLE === 1'b1) de_count++;
    if (DATA_OUT_ENABLE === 1'b1 || READY === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {62'b0, DATA_OUT_ENABLE, READY}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_enable", 64'(DATA_OUT_ENABLE), 64'(e.has_data));
        chk("ready", 64'(READY), 64'(e.rdy));
        if (READY === 1'b1) chk("data_enable_with_ready", 64'(DATA_ENABLE), 64'd0);
        if (e.has_data) begin
          if (e.nan) chk("data_nan", 64'((&DATA_OUT[62:52]) & (|DATA_OUT[51:0])), 64'd1);
          else       chk("data", DATA_OUT, e.data);
          chk("overflow", 64'(OVERFLOW_OUT), 64'(e.ovf));
        end
      end
    end
  end

  task automatic start_vec(input logic [63:0] n);
    @(negedge CLK);
    START   = 1'b1;
    SIZE_IN = n;
    if (n == 64'd0) sb.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b0));
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_de();
    int n = 0;
    while (DATA_ENABLE !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (DATA_ENABLE !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_data_enable: got timeout expected pulse");
    end
  endtask

  // operands go in the cycle after DATA_ENABLE; B follows A by gap cycles
  task automatic send_pair(input logic [63:0] a, input logic [63:0] b, input int gap,
                           input logic [63:0] q, input logic ovf, input logic rdy,
                           input logic nan);
    @(negedge CLK);
    DATA_A_IN        = a;
    DATA_A_IN_ENABLE = 1'b1;
    if (gap == 0) begin
      DATA_B_IN        = b;
      DATA_B_IN_ENABLE = 1'b1;
      sb.push_back(mk(1'b1, q, ovf, rdy, nan));
      @(negedge CLK);
      DATA_A_IN_ENABLE = 1'b0;
      DATA_B_IN_ENABLE = 1'b0;
    end else begin
      @(negedge CLK);
      DATA_A_IN_ENABLE = 1'b0;
      repeat (gap - 1) @(negedge CLK);
      DATA_B_IN        = b;
      DATA_B_IN_ENABLE = 1'b1;
      sb.push_back(mk(1'b1, q, ovf, rdy, nan));
      @(negedge CLK);
      DATA_B_IN_ENABLE = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_ready", 64'(READY), 64'd0);
    chk("reset_data_enable", 64'(DATA_ENABLE), 64'd0);
    chk("reset_out_enable", 64'(DATA_OUT_ENABLE), 64'd0);
    chk("reset_data_out", DATA_OUT, 64'd0);
    chk("reset_overflow", 64'(OVERFLOW_OUT), 64'd0);
    RST = 1'b0;

    // single element, both operands together
    de_count = 0;
    start_vec(64'd1);
    wait_de();
    send_pair(P_6, P_2, 0, P_3, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    chk("single_de_count", 64'(de_count), 64'd1);

    // three elements, A two cycles ahead of B
    de_count = 0;
    start_vec(64'd3);
    wait_de();
    send_pair(P_1, P_4, 2, P_Q, 1'b0, 1'b0, 1'b0);
    wait_de();
    send_pair(N_9, P_3, 2, N_3, 1'b0, 1'b0, 1'b0);
    wait_de();
    send_pair(P_1, P_3, 2, P_T, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    chk("stagger_de_count", 64'(de_count), 64'd3);

    // zero-length vector
    de_count = 0;
    start_vec(64'd0);
    repeat (4) @(negedge CLK);
    chk("size0_de_count", 64'(de_count), 64'd0);

    // START mid-vector is ignored
    de_count = 0;
    start_vec(64'd2);
    wait_de();
    send_pair(P_1, P_4, 0, P_Q, 1'b0, 1'b0, 1'b0);
    wait_de();
    @(negedge CLK);
    START   = 1'b1;
    SIZE_IN = 64'd5;
    @(negedge CLK);
    START = 1'b0;
    send_pair(P_6, P_2, 0, P_3, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge CLK);
    chk("midstart_de_count", 64'(de_count), 64'd2);

    // duplicate A enable: last value wins
    start_vec(64'd1);
    wait_de();
    @(negedge CLK);
    DATA_A_IN = P_2;
    DATA_A_IN_ENABLE = 1'b1;
    @(negedge CLK);
    DATA_A_IN = P_8;
    @(negedge CLK);
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN = P_2;
    DATA_B_IN_ENABLE = 1'b1;
    sb.push_back(mk(1'b1, P_4, 1'b0, 1'b1, 1'b0));
    @(negedge CLK);
    DATA_B_IN_ENABLE = 1'b0;
    repeat (2) @(negedge CLK);

    // divide by zero
    start_vec(64'd3);
    wait_de();
    send_pair(P_1, P_0, 0, PINF, 1'b1, 1'b0, 1'b0);
    wait_de();
    send_pair(N_1, N_0, 1, PINF, 1'b1, 1'b0, 1'b0);
    wait_de();
    send_pair(P_0, P_0, 0, 64'd0, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge CLK);

    // reset with A pending, then a fresh vector that must not reuse it
    start_vec(64'd1);
    wait_de();
    @(negedge CLK);
    DATA_A_IN = P_9;
    DATA_A_IN_ENABLE = 1'b1;
    @(negedge CLK);
    DATA_A_IN_ENABLE = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_data_out", DATA_OUT, 64'd0);
    chk("midrst_overflow", 64'(OVERFLOW_OUT), 64'd0);
    chk("midrst_ready", 64'(READY), 64'd0);
    chk("midrst_data_enable", 64'(DATA_ENABLE), 64'd0);
    chk("midrst_out_enable", 64'(DATA_OUT_ENABLE), 64'd0);
    start_vec(64'd1);
    wait_de();
    @(negedge CLK);
    DATA_B_IN = P_2;
    DATA_B_IN_ENABLE = 1'b1;
    @(negedge CLK);
    DATA_B_IN_ENABLE = 1'b0;
    DATA_A_IN = P_5;
    DATA_A_IN_ENABLE = 1'b1;
    sb.push_back(mk(1'b1, P_25, 1'b0, 1'b1, 1'b0));
    @(negedge CLK);
    DATA_A_IN_ENABLE = 1'b0;
    repeat (2) @(negedge CLK);

    // exponent overflow gives Inf without the divide-by-zero flag
    start_vec(64'd1);
    wait_de();
    send_pair(P_MX, P_H, 0, PINF, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
